winner_label_vote: RTL
======================

// Module: winner_label_vote
// PURPOSE
//  Downstream of the column: consumes its per-period valid/winner/no_winner result.
//  Train mode: builds a saturating neuron-by-label histogram from the winner and the supplied image label.
//  Infer mode: maps the winning neuron to the label it most often won for, via a sequential argmax scan.
//  The predicted label is reported with a one-cycle pulse.
// PARAMETERS
//  NEURONS     12  neurons per column; winner index width = $clog2(NEURONS)
//  LABELS      10  number of classes; LBITS = $clog2(LABELS) (localparam)
//  CNT_BITS     8  width of each histogram counter (saturating)
// PORTS
//  clk          in   1         clock
//  rst_n        in   1         asynchronous active-low reset
//  valid        in   1         column result strobe (one cycle per period)
//  winner       in   $clog2(NEURONS)  winning neuron index, qualified by valid
//  no_winner    in   1         column produced no spike this period
//  label        in   LBITS     ground-truth label of current image, sampled with valid
//  mode         in   1         0=train, 1=infer; sampled with valid
//  clear        in   1         synchronous wipe of histogram and flags
//  busy         out  1         argmax scan in progress
//  pred_valid   out  1         one-cycle prediction pulse
//  pred_label   out  LBITS     predicted label (held until next pred_valid)
//  pred_unknown out  1         prediction undefined (no winner / empty row); qualified by pred_valid
//  overrun      out  1         sticky: valid arrived while busy
//  hits         out  16        correct predictions (WLV_ACCURACY_EN)
//  total        out  16        predictions made (WLV_ACCURACY_EN)
// BEHAVIOUR
//  Reset: all counters 0; FSM IDLE; busy, pred_valid, pred_unknown, overrun = 0; pred_label = 0; hits, total = 0.
//  Storage: cnt[NEURONS][LABELS] of CNT_BITS; flop array, no RAM.
//  Train (valid & mode=0 & ~no_winner): cnt[winner][label] += 1 on the next edge.
//    Increment saturates at 2^CNT_BITS-1; no wrap.
//    no_winner drops the sample. label >= LABELS drops the sample. No pred_valid in train mode.
//  Infer, no_winner: next cycle pred_valid=1, pred_unknown=1; pred_label unchanged; no scan.
//  Infer, winner present: latch winner and label. IDLE -> SCAN; busy=1.
//  FSM IDLE -> SCAN -> DONE -> IDLE.
//    SCAN: idx 0..LABELS-1, one label per cycle.
//      best updated only when cnt[w][idx] > best_cnt (strict), so ties resolve to the lowest label.
//    DONE: pred_valid=1 for one cycle; busy=0 in this cycle.
//      pred_label = best. pred_unknown = 1 iff best_cnt == 0; then pred_label = 0.
//  Latency: valid at cycle t -> pred_valid at t+LABELS+1.
//  Column PERIOD must be > LABELS+2.
//  valid while busy (SCAN or DONE): sample ignored entirely (no train, no new scan); overrun <= 1 (sticky).
//  Histogram is frozen during a scan; train updates cannot occur while busy (see overrun rule).
//  clear: on the next edge zero cnt, overrun, hits, total; FSM -> IDLE.
//    A scan in progress is aborted with no pred_valid. clear has priority over a simultaneous valid (valid is dropped).
//  Async reset mid-scan: immediate return to reset state; no pred_valid.
//  winner >= NEURONS (only possible for non-power-of-2 NEURONS): treated as no_winner.
// CONFIGURATION
//  WLV_ACCURACY_EN defined:
//    label is latched at scan start. At DONE (or the no_winner pulse), total += 1.
//    hits += 1 iff ~pred_unknown & pred_label == latched label.
//    Both counters saturate at 16'hFFFF.
//  Undefined: no accuracy logic; hits and total are tied to 0.
// TESTING
//  T1 reset: assert rst_n=0 mid-SCAN -> busy=0, pred_valid never pulses, all cnt read 0 via a subsequent infer (pred_unknown=1).
//  T2 train/infer: 3x train(winner=4,label=7), 1x train(4,2); infer winner=4 -> pred_valid at t+11, pred_label=7, pred_unknown=0.
//  T3 tie/empty: train (5,3) and (5,1) once each; infer 5 -> pred_label=1. Infer winner=6 (empty row) -> pred_unknown=1, pred_label=0.
//  T4 saturation: CNT_BITS=8, 300x train(0,9), 1x train(0,8); infer 0 -> pred_label=9 and cnt[0][9]=255.
//  T5 overrun/clear: valid 3 cycles after an infer start -> overrun=1, the scan's result is unaffected.
//    Then clear during a new scan -> no pred_valid and overrun=0.
//  T6 (WLV_ACCURACY_EN): 4 infers, 3 correct, 1 no_winner -> total=4, hits=3. Macro undefined -> hits=total=0.

Source files
------------

// File: rtl/winner_label_vote_if.sv
// Column-result / prediction bundle between the column and winner_label_vote.
// The master drives the column result and control; the slave returns the prediction and status.
interface winner_label_vote_if #(
  parameter int NEURONS = 12,
  parameter int LABELS  = 10
);
  localparam int WBITS = $clog2(NEURONS);
  localparam int LBITS = $clog2(LABELS);

  logic             valid;
  logic [WBITS-1:0] winner;
  logic             no_winner;
  logic [LBITS-1:0] label;
  logic             mode;
  logic             clear;
  logic             busy;
  logic             pred_valid;
  logic [LBITS-1:0] pred_label;
  logic             pred_unknown;
  logic             overrun;
  logic [15:0]      hits;
  logic [15:0]      total;

  modport master (
    output valid, winner, no_winner, label, mode, clear,
    input  busy, pred_valid, pred_label, pred_unknown, overrun, hits, total
  );

  modport slave (
    input  valid, winner, no_winner, label, mode, clear,
    output busy, pred_valid, pred_label, pred_unknown, overrun, hits, total
  );
endinterface

// File: rtl/winner_label_vote.sv
// Neuron-by-label vote: trains a saturating histogram, infers by a sequential argmax scan.
// Optional accuracy counters (hits/total) are built when WLV_ACCURACY_EN is defined.
module winner_label_vote #(
  parameter int NEURONS  = 12,
  parameter int LABELS   = 10,
  parameter int CNT_BITS = 8
) (
  input logic                clk,
  input logic                rst_n,
  winner_label_vote_if.slave bus
);
  localparam int WBITS = $clog2(NEURONS);
  localparam int LBITS = $clog2(LABELS);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
  localparam logic [LBITS-1:0]    IDX_LAST = LBITS'(LABELS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                pred_valid_q, pred_valid_d;
  logic [LBITS-1:0]    pred_label_q, pred_label_d;
  logic                pred_unknown_q, pred_unknown_d;
  logic                overrun_q, overrun_d;
  logic [LBITS-1:0]    idx_q, idx_d;
  logic [WBITS-1:0]    win_q, win_d;
  logic [LBITS-1:0]    best_q, best_d;
  logic [CNT_BITS-1:0] best_cnt_q, best_cnt_d;
  logic [CNT_BITS-1:0] cnt_q [NEURONS][LABELS];
  logic [CNT_BITS-1:0] cnt_d [NEURONS][LABELS];
`ifdef WLV_ACCURACY_EN
  logic [LBITS-1:0]    lbl_q, lbl_d;
  logic [15:0]         hits_q, hits_d;
  logic [15:0]         total_q, total_d;
`endif

  logic                win_ok;
  logic                label_ok;
  logic [CNT_BITS-1:0] cur_cnt;
  logic                take;
  logic [LBITS-1:0]    nxt_best;
  logic [CNT_BITS-1:0] nxt_best_cnt;

  always_comb begin
    state_d        = state_q;
    busy_d         = busy_q;
    pred_valid_d   = 1'b0;
    pred_label_d   = pred_label_q;
    pred_unknown_d = pred_unknown_q;
    overrun_d      = overrun_q;
    idx_d          = idx_q;
    win_d          = win_q;
    best_d         = best_q;
    best_cnt_d     = best_cnt_q;
    cnt_d          = cnt_q;
`ifdef WLV_ACCURACY_EN
    lbl_d          = lbl_q;
    hits_d         = hits_q;
    total_d        = total_q;
`endif

    // Out-of-range winner indices behave exactly like a missing winner.
    win_ok       = !bus.no_winner && (int'(bus.winner) < NEURONS);
    label_ok     = int'(bus.label) < LABELS;
    cur_cnt      = cnt_q[win_q][idx_q];
    take         = cur_cnt > best_cnt_q;
    nxt_best     = take ? idx_q : best_q;
    nxt_best_cnt = take ? cur_cnt : best_cnt_q;

    if (bus.clear) begin
      cnt_d     = '{default: '0};
      overrun_d = 1'b0;
      state_d   = S_IDLE;
      busy_d    = 1'b0;
`ifdef WLV_ACCURACY_EN
      hits_d    = '0;
      total_d   = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.valid) begin
            if (!bus.mode) begin
              if (win_ok && label_ok && cnt_q[bus.winner][bus.label] != CNT_MAX)
                cnt_d[bus.winner][bus.label] = cnt_q[bus.winner][bus.label] + 1'b1;
            end else if (!win_ok) begin
              pred_valid_d   = 1'b1;
              pred_unknown_d = 1'b1;
            end else begin
              state_d    = S_SCAN;
              busy_d     = 1'b1;
              idx_d      = '0;
              win_d      = bus.winner;
              best_d     = '0;
              best_cnt_d = '0;
`ifdef WLV_ACCURACY_EN
              lbl_d      = bus.label;
`endif
            end
          end
        end
        S_SCAN: begin
          if (bus.valid) overrun_d = 1'b1;
          best_d     = nxt_best;
          best_cnt_d = nxt_best_cnt;
          if (idx_q == IDX_LAST) begin
            // Last label: publish the result straight from the final compare.
            state_d        = S_DONE;
            busy_d         = 1'b0;
            pred_valid_d   = 1'b1;
            pred_unknown_d = (nxt_best_cnt == '0);
            pred_label_d   = (nxt_best_cnt == '0) ? '0 : nxt_best;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.valid) overrun_d = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

`ifdef WLV_ACCURACY_EN
    if (pred_valid_d) begin
      if (total_q != 16'hFFFF) total_d = total_q + 16'd1;
      if (!pred_unknown_d && pred_label_d == lbl_q && hits_q != 16'hFFFF)
        hits_d = hits_q + 16'd1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      busy_q         <= 1'b0;
      pred_valid_q   <= 1'b0;
      pred_label_q   <= '0;
      pred_unknown_q <= 1'b0;
      overrun_q      <= 1'b0;
      idx_q          <= '0;
      win_q          <= '0;
      best_q         <= '0;
      best_cnt_q     <= '0;
      cnt_q          <= '{default: '0};
`ifdef WLV_ACCURACY_EN
      lbl_q          <= '0;
      hits_q         <= '0;
      total_q        <= '0;
`endif
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      pred_valid_q   <= pred_valid_d;
      pred_label_q   <= pred_label_d;
      pred_unknown_q <= pred_unknown_d;
      overrun_q      <= overrun_d;
      idx_q          <= idx_d;
      win_q          <= win_d;
      best_q         <= best_d;
      best_cnt_q     <= best_cnt_d;
      cnt_q          <= cnt_d;
`ifdef WLV_ACCURACY_EN
      lbl_q          <= lbl_d;
      hits_q         <= hits_d;
      total_q        <= total_d;
`endif
    end
  end

  assign bus.busy         = busy_q;
  assign bus.pred_valid   = pred_valid_q;
  assign bus.pred_label   = pred_label_q;
  assign bus.pred_unknown = pred_unknown_q;
  assign bus.overrun      = overrun_q;
`ifdef WLV_ACCURACY_EN
  assign bus.hits         = hits_q;
  assign bus.total        = total_q;
`else
  assign bus.hits         = '0;
  assign bus.total        = '0;
`endif
endmodule
